// File: rtl/algo_1r6w_wr_sched_if.sv
// Requester/core bus of the 1R6W write scheduler: requester side is the master,
// the scheduler is the slave.
interface algo_1r6w_wr_sched_if #(
    parameter int NUMREQ  = 8,
    parameter int NUMWRPT = 6,
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13
);
    logic                       ready;
    logic                       wr_bp;
    logic [NUMREQ-1:0]          req;
    logic [NUMREQ*BITADDR-1:0]  req_adr;
    logic [NUMREQ*WIDTH-1:0]    req_din;
    logic [NUMREQ-1:0]          req_gnt;
    logic [NUMWRPT-1:0]         write;
    logic [NUMWRPT*BITADDR-1:0] wr_adr;
    logic [NUMWRPT*WIDTH-1:0]   din;
    logic [15:0]                stall_cnt;

    modport master (
        output ready, wr_bp, req, req_adr, req_din,
        input  req_gnt, write, wr_adr, din, stall_cnt
    );

    modport slave (
        input  ready, wr_bp, req, req_adr, req_din,
        output req_gnt, write, wr_adr, din, stall_cnt
    );
endinterface

// File: rtl/algo_1r6w_wr_sched.sv
// Round-robin scheduler packing up to NUMWRPT of NUMREQ write requests onto core write ports.
// Define ALGO_WRSCHED_ADRCHK_EN to refuse same-cycle grants that collide on address.
module algo_1r6w_wr_sched #(
    parameter int NUMREQ  = 8,
    parameter int BITREQ  = 3,
    parameter int NUMWRPT = 6,
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13
) (
    input logic                 clk,
    input logic                 rst,
    algo_1r6w_wr_sched_if.slave wr_if
);
    logic [BITADDR-1:0]         adr_a   [NUMREQ];
    logic [WIDTH-1:0]           din_a   [NUMREQ];
    logic [BITADDR-1:0]         sel_adr [NUMWRPT];
    logic [WIDTH-1:0]           sel_din [NUMWRPT];
    logic [NUMWRPT-1:0]         sel_vld;
    logic [NUMREQ-1:0]          gnt;
    logic                       en;
    logic                       hit;
    logic                       any;
    int unsigned                cnt;
    logic [BITREQ:0]            idx_w;
    logic [BITREQ-1:0]          idx;
    logic [BITREQ-1:0]          last;
    logic [BITREQ:0]            nxt;

    logic [NUMWRPT-1:0]         write_q;
    logic [NUMWRPT*BITADDR-1:0] wr_adr_q;
    logic [NUMWRPT*WIDTH-1:0]   din_q;
    logic [BITREQ-1:0]          rr_ptr_q, rr_ptr_d;
    logic [15:0]                stall_q, stall_d;

    for (genvar g = 0; g < NUMREQ; g++) begin : g_unpack
        assign adr_a[g] = wr_if.req_adr[g*BITADDR +: BITADDR];
        assign din_a[g] = wr_if.req_din[g*WIDTH +: WIDTH];
    end

    always_comb begin
        gnt     = '0;
        sel_vld = '0;
        for (int unsigned k = 0; k < NUMWRPT; k++) begin
            sel_adr[k] = '0;
            sel_din[k] = '0;
        end
        cnt   = 0;
        last  = '0;
        any   = 1'b0;
        hit   = 1'b0;
        idx_w = '0;
        idx   = '0;
        en    = wr_if.ready && !wr_if.wr_bp && !rst;
        // Wrap by subtraction so non-power-of-two NUMREQ indexes correctly.
        for (int unsigned i = 0; i < NUMREQ; i++) begin
            idx_w = {1'b0, rr_ptr_q} + (BITREQ+1)'(i);
            if (idx_w >= (BITREQ+1)'(NUMREQ))
                idx_w = idx_w - (BITREQ+1)'(NUMREQ);
            idx = idx_w[BITREQ-1:0];
            hit = 1'b0;
`ifdef ALGO_WRSCHED_ADRCHK_EN
            for (int unsigned k = 0; k < NUMWRPT; k++)
                if (sel_vld[k] && (sel_adr[k] == adr_a[idx]))
                    hit = 1'b1;
`endif
            if (en && wr_if.req[idx] && (cnt < NUMWRPT) && !hit) begin
                for (int unsigned k = 0; k < NUMWRPT; k++) begin
                    if (k == cnt) begin
                        sel_vld[k] = 1'b1;
                        sel_adr[k] = adr_a[idx];
                        sel_din[k] = din_a[idx];
                    end
                end
                gnt[idx] = 1'b1;
                cnt      = cnt + 1;
                last     = idx;
                any      = 1'b1;
            end
        end

        nxt      = {1'b0, last} + (BITREQ+1)'(1);
        rr_ptr_d = rr_ptr_q;
        if (any)
            rr_ptr_d = (nxt >= (BITREQ+1)'(NUMREQ)) ? '0 : nxt[BITREQ-1:0];

        stall_d = stall_q;
        if ((|wr_if.req) && (wr_if.wr_bp || !wr_if.ready) && (stall_q != '1))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q  <= '0;
            wr_adr_q <= '0;
            din_q    <= '0;
            rr_ptr_q <= '0;
            stall_q  <= '0;
        end else begin
            write_q <= sel_vld;
            // Idle ports keep their last address/data.
            for (int unsigned k = 0; k < NUMWRPT; k++) begin
                if (sel_vld[k]) begin
                    wr_adr_q[k*BITADDR +: BITADDR] <= sel_adr[k];
                    din_q[k*WIDTH +: WIDTH]        <= sel_din[k];
                end
            end
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
        end
    end

    assign wr_if.req_gnt   = gnt;
    assign wr_if.write     = write_q;
    assign wr_if.wr_adr    = wr_adr_q;
    assign wr_if.din       = din_q;
    assign wr_if.stall_cnt = stall_q;
endmodule

// File: tb/tb_algo_1r6w_wr_sched.sv
// Directed bench for algo_1r6w_wr_sched: 8-requester/6-port table plus a 6-requester/2-port wrap check.
module tb_algo_1r6w_wr_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    algo_1r6w_wr_sched_if #(.NUMREQ(8), .NUMWRPT(6), .WIDTH(32), .BITADDR(13)) bus ();
    algo_1r6w_wr_sched_if #(.NUMREQ(6), .NUMWRPT(2), .WIDTH(32), .BITADDR(13)) bus6 ();

    algo_1r6w_wr_sched #(.NUMREQ(8), .BITREQ(3), .NUMWRPT(6), .WIDTH(32), .BITADDR(13)) dut (
        .clk(clk), .rst(rst), .wr_if(bus.slave)
    );
    algo_1r6w_wr_sched #(.NUMREQ(6), .BITREQ(3), .NUMWRPT(2), .WIDTH(32), .BITADDR(13)) dut6 (
        .clk(clk), .rst(rst), .wr_if(bus6.slave)
    );

    function automatic logic [31:0] dat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    logic [12:0] tadr [8];
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            bus.req_adr[i*13 +: 13] = tadr[i];
            bus.req_din[i*32 +: 32] = dat(i);
        end
        for (int i = 0; i < 6; i++) begin
            bus6.req_adr[i*13 +: 13] = tadr[i];
            bus6.req_din[i*32 +: 32] = dat(i);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        wr_bp;
        logic [7:0]  req;
        logic [7:0]  gnt;
        logic [5:0]  wr;
        logic [15:0] stall;
        logic [31:0] p0;
        logic [31:0] p1;
    } vec_t;

    vec_t tv [13];

    initial begin
        logic [7:0] r;
        logic [7:0] e;
        logic [5:0] g6 [4];

        tv[0]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 6'h00, 16'd0, 32'h0,  32'h0};
        tv[1]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 6'h00, 16'd0, 32'h0,  32'h0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h3F, 6'h3F, 16'd0, dat(0), dat(1)};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hCF, 6'h3F, 16'd0, dat(6), dat(7)};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hF3, 6'h3F, 16'd0, dat(4), dat(5)};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h00, 6'h00, 16'd1, dat(4), dat(5)};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h00, 6'h00, 16'd2, dat(4), dat(5)};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h00, 6'h00, 16'd3, dat(4), dat(5)};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 6'h01, 16'd3, dat(0), dat(5)};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 6'h00, 16'd3, dat(0), dat(5)};
        tv[10] = '{1'b0, 1'b1, 1'b0, 8'h84, 8'h84, 6'h03, 16'd3, dat(2), dat(7)};
        tv[11] = '{1'b0, 1'b1, 1'b0, 8'h81, 8'h81, 6'h03, 16'd3, dat(0), dat(7)};
        tv[12] = '{1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 6'h01, 16'd3, dat(7), dat(7)};

        for (int i = 0; i < 8; i++) tadr[i] = 13'h100 + 13'(i);
        rst        = 1'b1;
        bus.ready  = 1'b0;
        bus.wr_bp  = 1'b0;
        bus.req    = '0;
        bus6.ready = 1'b1;
        bus6.wr_bp = 1'b0;
        bus6.req   = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            rst       = tv[i].rst;
            bus.ready = tv[i].ready;
            bus.wr_bp = tv[i].wr_bp;
            bus.req   = tv[i].req;
            #1;
            chk($sformatf("v%0d gnt", i), 32'(bus.req_gnt), 32'(tv[i].gnt));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d write", i), 32'(bus.write), 32'(tv[i].wr));
            chk($sformatf("v%0d stall", i), 32'(bus.stall_cnt), 32'(tv[i].stall));
            chk($sformatf("v%0d port0 din", i), bus.din[31:0], tv[i].p0);
            chk($sformatf("v%0d port1 din", i), bus.din[63:32], tv[i].p1);
        end
        chk("port0 adr after v12", 32'(bus.wr_adr[12:0]), 32'h107);

        // Saturation of the stall counter.
        bus.ready = 1'b0;
        bus.req   = 8'h01;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat gnt", 32'(bus.req_gnt), 32'h0);
        chk("sat stall", 32'(bus.stall_cnt), 32'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        chk("sat stall hold", 32'(bus.stall_cnt), 32'hFFFF);

        // Reset the cycle after a grant.
        bus.ready = 1'b1;
        bus.req   = 8'h01;
        #1;
        chk("pre-rst gnt", 32'(bus.req_gnt), 32'h01);
        @(posedge clk);
        #1;
        chk("pre-rst write", 32'(bus.write), 32'h01);
        rst     = 1'b1;
        bus.req = 8'hFF;
        #1;
        chk("rst gnt", 32'(bus.req_gnt), 32'h0);
        @(posedge clk);
        #1;
        chk("rst write", 32'(bus.write), 32'h0);
        chk("rst stall", 32'(bus.stall_cnt), 32'h0);
        chk("rst din", bus.din[31:0], 32'h0);
        rst = 1'b0;
        #1;
        chk("post-rst gnt", 32'(bus.req_gnt), 32'h3F);
        @(posedge clk);
        #1;
        chk("post-rst write", 32'(bus.write), 32'h3F);

        // Same-address requests.
        rst     = 1'b1;
        bus.req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tadr[i] = 13'h0A5;
        r       = 8'h07;
        bus.req = r;
`ifdef ALGO_WRSCHED_ADRCHK_EN
        for (int c = 0; c < 3; c++) begin
            e = 8'h01 << c;
            #1;
            chk($sformatf("adrchk gnt c%0d", c), 32'(bus.req_gnt), 32'(e));
            @(posedge clk);
            #1;
            chk($sformatf("adrchk write c%0d", c), 32'(bus.write), 32'h01);
            chk($sformatf("adrchk adr c%0d", c), 32'(bus.wr_adr[12:0]), 32'h0A5);
            r       = r & ~e;
            bus.req = r;
        end
`else
        e = 8'h07;
        #1;
        chk("sameadr gnt", 32'(bus.req_gnt), 32'(e));
        @(posedge clk);
        #1;
        chk("sameadr write", 32'(bus.write), 32'h07);
        chk("sameadr adr1", 32'(bus.wr_adr[25:13]), 32'h0A5);
        chk("sameadr adr2", 32'(bus.wr_adr[38:26]), 32'h0A5);
        chk("sameadr din2", bus.din[95:64], dat(2));
`endif
        bus.req = '0;
        for (int i = 0; i < 8; i++) tadr[i] = 13'h100 + 13'(i);

        // Non-power-of-two requester count: pointer must wrap 6 -> 0.
        g6[0] = 6'h03;
        g6[1] = 6'h0C;
        g6[2] = 6'h30;
        g6[3] = 6'h03;
        bus6.req = 6'h3F;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("n6 gnt c%0d", c), 32'(bus6.req_gnt), 32'(g6[c]));
            @(posedge clk);
            #1;
            chk($sformatf("n6 write c%0d", c), 32'(bus6.write), 32'h3);
        end
        bus6.req = 6'h11;
        #1;
        chk("n6 wrap gnt", 32'(bus6.req_gnt), 32'h11);
        @(posedge clk);
        #1;
        chk("n6 wrap write", 32'(bus6.write), 32'h3);
        chk("n6 wrap port0", bus6.din[31:0], dat(4));
        chk("n6 wrap port1", bus6.din[63:32], dat(0));
        bus6.req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
